// File: rtl/audio_pkg.sv
// Shared types and constants for the audio clip scheduler.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int HOLD_TIME_3200HZ = 31250;
    localparam int ADDR_W_DEF       = 17;
    localparam int BRAM_RD_LAT      = 1;

    // Requester id width; a single requester still gets a 1-bit id.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/audio_clip_scheduler_prio_enc.sv
// Fixed-priority encoder over pending requests; the highest index wins.
module pending_prio_enc
    import audio_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend_i,
    input  logic [IDW-1:0]     act_i,
    output logic               any_o,
    output logic [IDW-1:0]     sel_o,
    output logic               ge_o
);

    always_comb begin
        any_o = |pend_i;
        sel_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend_i[i]) sel_o = IDW'(i);
        end
        // ">=" so that a re-request of the playing id restarts it
        ge_o = any_o && (sel_o >= act_i);
    end

endmodule

// File: rtl/audio_clip_scheduler.sv
// Shares one sample BRAM among NUM_REQ clip players; the granted clip is
// streamed one sample per HOLD_TIME clocks and held on amp_out.
module audio_clip_scheduler
    import audio_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int HOLD_TIME = HOLD_TIME_3200HZ
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base,
    input  logic [NUM_REQ*ADDR_W-1:0] req_len,
    input  logic [NUM_REQ-1:0]        req_loop,
    input  logic                      stop,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_en,
    input  logic [15:0]               mem_data,
    output logic signed [15:0]        amp_out,
    output logic                      busy,
    output logic [id_w(NUM_REQ)-1:0]  active_id,
    output logic [NUM_REQ-1:0]        done
);

    localparam int IDW = id_w(NUM_REQ);
    localparam int HCW = $clog2(HOLD_TIME);
    // Boundary leaves room for FETCH plus the BRAM latency before the next LOAD.
    localparam logic [HCW-1:0] HC_BOUND = HCW'(HOLD_TIME - 2 - BRAM_RD_LAT);
    localparam logic [HCW-1:0] HC_LAST  = HCW'(HOLD_TIME - 1);

    state_t                          state_q;
    logic [NUM_REQ-1:0]              pend_q, pend_d;
    logic [NUM_REQ-1:0][ADDR_W-1:0]  base_q, len_q;
    logic [NUM_REQ-1:0]              loop_q;
    logic [ADDR_W-1:0]               addr_q, remain_q;
    logic [HCW-1:0]                  hold_q;
    logic [15:0]                     amp_q;
    logic                            mem_en_q;
    logic [IDW-1:0]                  act_q;
    logic [NUM_REQ-1:0]              done_q;

    logic [NUM_REQ-1:0] cap, grant_oh;
    logic               any, ge, take;
    logic [IDW-1:0]     sel;

    pending_prio_enc #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_enc (
        .pend_i (pend_q),
        .act_i  (act_q),
        .any_o  (any),
        .sel_o  (sel),
        .ge_o   (ge)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cap[i] = req[i] && (req_len[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    // A grant happens from IDLE, or as a preemption at a sample boundary.
    assign take = (state_q == ST_IDLE && any) ||
                  (state_q == ST_HOLD && hold_q == HC_BOUND && ge);

    // A capture in the same cycle as a grant of that id keeps the bit set.
    always_comb begin
        grant_oh = '0;
        if (take) grant_oh[sel] = 1'b1;
        pend_d = (pend_q & ~grant_oh) | cap;
        if (stop) pend_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            base_q   <= '0;
            len_q    <= '0;
            loop_q   <= '0;
            addr_q   <= '0;
            remain_q <= '0;
            hold_q   <= '0;
            amp_q    <= '0;
            mem_en_q <= 1'b0;
            act_q    <= '0;
            done_q   <= '0;
        end else begin
            pend_q   <= pend_d;
            mem_en_q <= 1'b0;
            done_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cap[i] && !stop) begin
                    base_q[i] <= req_base[i*ADDR_W +: ADDR_W];
                    len_q[i]  <= req_len[i*ADDR_W +: ADDR_W];
                    loop_q[i] <= req_loop[i];
                end
            end
            if (stop) begin
                state_q <= ST_IDLE;
                amp_q   <= '0;
                act_q   <= '0;
            end else if (take) begin
                act_q    <= sel;
                addr_q   <= base_q[sel];
                remain_q <= len_q[sel];
                mem_en_q <= 1'b1;
                state_q  <= ST_FETCH;
            end else begin
                case (state_q)
                    ST_FETCH: state_q <= ST_LOAD;
                    ST_LOAD: begin
                        amp_q   <= mem_data;
                        hold_q  <= '0;
                        state_q <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (hold_q == HC_BOUND && remain_q > ADDR_W'(1)) begin
                            addr_q   <= addr_q + ADDR_W'(1);
                            remain_q <= remain_q - ADDR_W'(1);
                            mem_en_q <= 1'b1;
                            state_q  <= ST_FETCH;
                        end else if (hold_q == HC_BOUND && loop_q[act_q]) begin
                            addr_q   <= base_q[act_q];
                            remain_q <= len_q[act_q];
                            mem_en_q <= 1'b1;
                            state_q  <= ST_FETCH;
                        end else if (hold_q == HC_LAST) begin
                            // Final sample of a one-shot clip is held a full period.
                            done_q[act_q] <= 1'b1;
                            amp_q         <= '0;
                            act_q         <= '0;
                            state_q       <= ST_IDLE;
                        end else begin
                            hold_q <= hold_q + HCW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_en    = mem_en_q;
    assign amp_out   = amp_q;
    assign busy      = (state_q != ST_IDLE);
    assign active_id = act_q;
    assign done      = done_q;

endmodule

// File: doc/audio_clip_scheduler.md
Name: audio_clip_scheduler

Overview:
Shares one read-only audio sample BRAM (int16 samples, 1-cycle read latency) among NUM_REQ sound sources, e.g. background music and game sound effects.
- Latches clip requests, arbitrates them by fixed priority, and walks the granted clip's address range at one sample per HOLD_TIME clocks.
- Presents the current sample as a held amplitude to the audio output stage.
- Replaces free-running per-clip players, so only one BRAM port is needed.

Parameters:
NUM_REQ, 4, number of requesters; index NUM_REQ-1 has the highest priority
ADDR_W, 17, BRAM address width
HOLD_TIME, 31250, clocks per sample (100 MHz / 3200 Hz); must be >= 3

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
req  in  NUM_REQ  per-source start pulse (1 cycle)
req_base  in  NUM_REQ*ADDR_W  flattened first-sample address per source; sampled with req
req_len  in  NUM_REQ*ADDR_W  flattened clip length in samples; sampled with req
req_loop  in  NUM_REQ  replay from base at end of clip; sampled with req
stop  in  1  abort playback and clear all pending requests
mem_addr  out  ADDR_W  BRAM read address
mem_en  out  1  BRAM read enable
mem_data  in  16  BRAM read data, valid the cycle after mem_en
amp_out  out  16  signed sample, held for the sample period
busy  out  1  high when state != IDLE
active_id  out  $clog2(NUM_REQ)  id of the clip being played; 0 when idle
done  out  NUM_REQ  1-cycle pulse on natural end of a non-looping clip

Behaviour:
- Reset (rst==0 at clk edge) has priority over all inputs. It sets:
  - state=IDLE
  - pending, base, len and loop registers cleared
  - amp_out=0, mem_addr=0, mem_en=0, busy=0, active_id=0, done=0
  - the same applies mid-playback.
- Request capture: req[i]=1 with req_len[i]!=0 does three things:
  - sets pending[i]
  - stores base[i], len[i], loop[i]
  - overwrites any earlier pending request for that id.
  req with len 0 is ignored. A req and a grant of the same id in the same cycle leaves the bit set, so the new request wins.
- Selection: the highest set pending bit, via a priority encoder. Granting an id clears its pending bit.
- States:
  - IDLE: if any pending, grant sel, load cur_addr=base[sel] and remaining=len[sel], go to FETCH.
  - FETCH (1 cycle): mem_addr=cur_addr, mem_en=1, go to LOAD.
  - LOAD (1 cycle): amp_out<=mem_data, hold_cnt<=0, go to HOLD.
  - HOLD: hold_cnt increments each cycle. When hold_cnt==HOLD_TIME-3, the sample boundary is reached, so amp_out updates exactly every HOLD_TIME cycles.
- Sample boundary, resolved in this order:
  1. Preemption: if pending has an id >= active_id (a same-id re-request means restart), grant it, load its base and len, go to FETCH. The preempted clip gets no done pulse.
  2. If remaining>1: cur_addr+1, remaining-1, go to FETCH.
  3. If it was the last sample and loop is set: cur_addr=base, remaining=len, go to FETCH.
  4. If it was the last sample and loop is clear: pulse done[active_id], amp_out<=0, go to IDLE. Lower-priority pending requests are then served from IDLE on the next cycle.
- Lower-priority pending requests never preempt; they wait.
- cur_addr wraps modulo 2^ADDR_W; no range check is performed.
- stop, in any state except reset: state=IDLE, amp_out=0, mem_en=0, pending cleared, no done pulse. stop and req in the same cycle: stop wins and req is dropped.
- First sample latency: req at cycle T gives amp_out valid at T+4 (pending set T+1, grant T+1→FETCH T+2, LOAD T+3, amp_out updated at T+4).
- mem_en is high only in FETCH.

Decomposition:
- audio_pkg holds:
  - state encoding (IDLE, FETCH, LOAD, HOLD)
  - HOLD_TIME_3200HZ=31250
  - default ADDR_W
  - BRAM read latency constant (1)
- Sub-module pending_prio_enc (NUM_REQ): returns any_pending, the selected id, and a "pending id >= active_id" flag.

Test Plan:
- HOLD_TIME=8, BRAM[i]=i. req[0] with base=10, len=3, loop=0 → amp_out goes 10, 11, 12 at T+4, T+12, T+20; done[0] pulses at T+28; amp_out=0; busy=0.
- Same as above with loop=1 → sequence 10, 11, 12, 10, 11 …; no done pulse.
- req[0] playing (base 10, len 100), then req[2] (base 50, len 2) mid-sample → switch at the next boundary: amp_out 50, 51; done[2] pulses; then idle. Clip 0 is not resumed.
- req[2] playing, then req[1] → clip 2 completes; done[2]; next cycle grant 1; amp_out = base[1] 3 cycles later.
- stop during HOLD with req[3] pending → IDLE next cycle; amp_out=0; pending=0; no done pulse.
- rst low mid-FETCH → all outputs 0 the next cycle. req with len=0 → busy stays 0.
